// File: rtl/bit_pattern_player.sv
// bit_pattern_player: replays a pattern held in a 1-bit-wide block RAM as a
// slow serial stream, one bit per 2^PRESCALE_WIDTH clocks, optionally looping.
// The pattern is written through the load port while idle, then start kicks
// off playback. A PRIME cycle fills the synchronous read register before the
// first bit is presented. A DRAIN period keeps the final bit on the line for a
// full period before done is raised.
module bit_pattern_player #(
  parameter int ADDR_WIDTH     = 14,
  parameter int PRESCALE_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  loadEnable,
  input  logic [ADDR_WIDTH-1:0] loadAddress,
  input  logic                  loadData,
  input  logic [ADDR_WIDTH-1:0] lastIndex,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  output logic                  bitOut,
  output logic                  bitValid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0]     INDEX_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                state;
  logic [1:0]                nextState;
  logic [ADDR_WIDTH-1:0]     readIndex;
  logic [ADDR_WIDTH-1:0]     lastLatched;
  logic                      loopLatched;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      rdData;
  logic                      prescaleTick;
  logic                      atLast;
  logic                      startAccepted;

  logic mem [DEPTH];

  assign prescaleTick  = (prescale == '0);
  assign atLast        = (readIndex == lastLatched);
  assign startAccepted = start && !stop;

  // Pattern RAM: writes only while idle, read register follows readIndex every cycle
  always_ff @(posedge clk) begin
    if (loadEnable && (state == IDLE)) begin
      mem[loadAddress] <= loadData;
    end
    rdData <= mem[readIndex];
  end

  // Next-state selection; stop pre-empts everything once playback is under way
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startAccepted) begin
          nextState = PRIME;
        end
      end
      PRIME: begin
        nextState = stop ? IDLE : PLAY;
      end
      PLAY: begin
        if (stop) begin
          nextState = IDLE;
        end else if (prescaleTick && atLast && !loopLatched) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (stop || prescaleTick) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Playback datapath: prescaler, read pointer, output bit, strobe and status flags
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      readIndex   <= '0;
      lastLatched <= '0;
      loopLatched <= 1'b0;
      prescale    <= '0;
      bitOut      <= 1'b0;
      bitValid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state    <= nextState;
      busy     <= (nextState != IDLE);
      bitValid <= 1'b0;
      case (state)
        IDLE: begin
          if (startAccepted) begin
            lastLatched <= lastIndex;
            loopLatched <= loop;
            readIndex   <= '0;
            prescale    <= '0;
            done        <= 1'b0;
          end
        end
        PRIME: begin
          if (stop) begin
            bitOut <= 1'b0;
          end
        end
        PLAY: begin
          if (stop) begin
            bitOut <= 1'b0;
          end else begin
            prescale <= prescale + PRESCALE_ONE;
            if (prescaleTick) begin
              bitOut   <= rdData;
              bitValid <= 1'b1;
              if (!atLast) begin
                readIndex <= readIndex + INDEX_ONE;
              end else if (loopLatched) begin
                readIndex <= '0;
              end
            end
          end
        end
        DRAIN: begin
          if (stop) begin
            bitOut <= 1'b0;
          end else begin
            prescale <= prescale + PRESCALE_ONE;
            if (prescaleTick) begin
              bitOut <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        default: begin
          bitOut <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_pattern_player.sv
// tb_bit_pattern_player: directed, table-driven bench for bit_pattern_player
// with a 4-bit address space and P = 4 clocks per output bit.
module tb_bit_pattern_player;

  localparam int ADDR_WIDTH     = 4;
  localparam int PRESCALE_WIDTH = 2;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  loadEnable;
  logic [ADDR_WIDTH-1:0] loadAddress;
  logic                  loadData;
  logic [ADDR_WIDTH-1:0] lastIndex;
  logic                  loop;
  logic                  start;
  logic                  stop;
  logic                  bitOut;
  logic                  bitValid;
  logic                  busy;
  logic                  done;

  int checks      = 0;
  int failures    = 0;
  int strobeCount = 0;

  typedef struct {
    int         adv;
    logic       startIn;
    logic       stopIn;
    logic [3:0] expStatus;
    string      name;
  } vector_t;

  vector_t vecs [11];

  bit_pattern_player #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .loadEnable (loadEnable),
    .loadAddress(loadAddress),
    .loadData   (loadData),
    .lastIndex  (lastIndex),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .bitOut     (bitOut),
    .bitValid   (bitValid),
    .busy       (busy),
    .done       (done)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // One clock edge, then settle and count any strobe produced at that edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (bitValid === 1'b1) strobeCount++;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Status is packed as {bitOut, bitValid, busy, done}
  task automatic checkOutput(input string name, input logic [3:0] expected);
    logic [3:0] actual;
    actual = {bitOut, bitValid, busy, done};
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: {bitOut,bitValid,busy,done} got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic loadBit(input logic [ADDR_WIDTH-1:0] addr, input logic data);
    loadEnable  = 1'b1;
    loadAddress = addr;
    loadData    = data;
    tick();
    loadEnable  = 1'b0;
  endtask

  // Issues start at edge k, then scrambles lastIndex/loop to prove they were latched
  task automatic startRun(input logic [ADDR_WIDTH-1:0] last, input logic lp);
    lastIndex = last;
    loop      = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    lastIndex = ~last;
    loop      = ~lp;
  endtask

  // Inputs of a record are held for its first edge only
  task automatic applyStimulus(input vector_t v);
    start = v.startIn;
    stop  = v.stopIn;
    tick();
    if (v.startIn) begin
      lastIndex = ~lastIndex;
      loop      = ~loop;
    end
    start = 1'b0;
    stop  = 1'b0;
    advance(v.adv - 1);
    checkOutput(v.name, v.expStatus);
  endtask

  task automatic runTable(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(vecs[i]);
  endtask

  initial begin
    int s;
    logic [15:0] pat;

    // Pattern 1,0,1,1 with lastIndex=3, loop=0; a start pulse at k+3 must be ignored
    vecs[0]  = '{1, 1'b1, 1'b0, 4'b0010, "s2 start edge k"};
    vecs[1]  = '{1, 1'b0, 1'b0, 4'b0010, "s2 prime k+1"};
    vecs[2]  = '{1, 1'b0, 1'b0, 4'b1110, "s2 strobe0 k+2"};
    vecs[3]  = '{1, 1'b1, 1'b0, 4'b1010, "s2 start while busy k+3"};
    vecs[4]  = '{3, 1'b0, 1'b0, 4'b0110, "s2 strobe1 k+6"};
    vecs[5]  = '{1, 1'b0, 1'b0, 4'b0010, "s2 hold k+7"};
    vecs[6]  = '{3, 1'b0, 1'b0, 4'b1110, "s2 strobe2 k+10"};
    vecs[7]  = '{4, 1'b0, 1'b0, 4'b1110, "s2 strobe3 k+14"};
    vecs[8]  = '{3, 1'b0, 1'b0, 4'b1010, "s2 drain k+17"};
    vecs[9]  = '{1, 1'b0, 1'b0, 4'b0001, "s2 done k+18"};
    vecs[10] = '{2, 1'b0, 1'b0, 4'b0001, "s2 done sticky k+20"};

    resetN      = 1'b0;
    loadEnable  = 1'b0;
    loadAddress = '0;
    loadData    = 1'b0;
    lastIndex   = '0;
    loop        = 1'b0;
    start       = 1'b1;
    stop        = 1'b0;

    // Reset held 3 cycles with start asserted
    advance(3);
    checkOutput("reset outputs", 4'b0000);
    start  = 1'b0;
    resetN = 1'b1;
    tick();
    checkOutput("idle after reset", 4'b0000);

    loadBit(4'd0, 1'b1);
    loadBit(4'd1, 1'b0);
    loadBit(4'd2, 1'b1);
    loadBit(4'd3, 1'b1);
    checkOutput("load keeps idle", 4'b0000);

    lastIndex = 4'd3;
    loop      = 1'b0;
    s = strobeCount;
    runTable(0, 10);
    checkCount("s2 strobe count", strobeCount - s, 4);

    // Reset at edge k+7 of the same run, then replay from retained memory
    lastIndex = 4'd3;
    loop      = 1'b0;
    runTable(0, 4);
    resetN = 1'b0;
    tick();
    checkOutput("s6 reset mid-play", 4'b0000);
    resetN = 1'b1;
    tick();
    checkOutput("s6 idle after reset", 4'b0000);
    lastIndex = 4'd3;
    loop      = 1'b0;
    s = strobeCount;
    runTable(0, 10);
    checkCount("s6 replay strobe count", strobeCount - s, 4);

    // Looping 1,0 pattern stopped mid-period
    loadBit(4'd0, 1'b1);
    loadBit(4'd1, 1'b0);
    startRun(4'd1, 1'b1);
    checkOutput("s3 start clears done", 4'b0010);
    advance(2);
    checkOutput("s3 loop strobe0", 4'b1110);
    for (int i = 1; i < 5; i++) begin
      advance(4);
      checkOutput($sformatf("s3 loop strobe%0d", i), {(i % 2 == 0), 3'b110});
    end
    advance(1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("s3 stop mid-period", 4'b0000);
    s = strobeCount;
    advance(8);
    checkCount("s3 no strobes after stop", strobeCount - s, 0);
    checkOutput("s3 stays idle", 4'b0000);

    // Stop landing on a prescale tick edge wins over the tick
    s = strobeCount;
    startRun(4'd1, 1'b1);
    advance(5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop at tick edge", 4'b0000);
    checkCount("stop at tick strobes", strobeCount - s, 1);

    // Load while busy is ignored
    startRun(4'd1, 1'b0);
    advance(1);
    loadBit(4'd0, 1'b0);
    checkOutput("s4 strobe0 during load", 4'b1110);
    advance(8);
    checkOutput("s4 run done", 4'b0001);

    // lastIndex=0 plays one bit, showing the busy-time write never landed
    startRun(4'd0, 1'b0);
    advance(2);
    checkOutput("s4 write ignored", 4'b1110);
    s = strobeCount;
    advance(3);
    checkOutput("s5 single bit held", 4'b1010);
    advance(1);
    checkOutput("s5 single bit done", 4'b0001);
    checkCount("s5 single strobe", strobeCount - s, 0);

    // Load together with start: new value is played
    loadEnable  = 1'b1;
    loadAddress = 4'd0;
    loadData    = 1'b0;
    lastIndex   = 4'd0;
    loop        = 1'b0;
    start       = 1'b1;
    tick();
    loadEnable  = 1'b0;
    start       = 1'b0;
    advance(2);
    checkOutput("s4 load with start", 4'b0110);
    advance(4);
    checkOutput("s4 load with start done", 4'b0001);

    // Start and stop together in idle: nothing happens, done kept
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    advance(3);
    checkOutput("start+stop in idle", 4'b0001);

    // Full memory, lastIndex all ones
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) loadBit(4'(i), pat[i]);
    s = strobeCount;
    startRun(4'hF, 1'b0);
    advance(2);
    checkOutput("full strobe0", {pat[0], 3'b110});
    for (int i = 1; i < 16; i++) begin
      advance(4);
      checkOutput($sformatf("full strobe%0d", i), {pat[i], 3'b110});
    end
    advance(3);
    checkOutput("full drain", {pat[15], 3'b010});
    advance(1);
    checkOutput("full done", 4'b0001);
    checkCount("full strobe count", strobeCount - s, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
